system_hex_bcd: RTL and testbench

SYSTEM_HEX_BCD -- requirements
Module: system_hex_bcd

---
 rtl/system_hex_bcd_pkg.sv | 45 ++++
 rtl/system_hex_bcd_seg7.sv | 30 +++
 rtl/system_hex_bcd.sv | 166 ++++++++++++++++
 tb/tb_system_hex_bcd.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_hex_bcd_pkg.sv
// Shared definitions for the hex-to-BCD converter: register offsets, FSM
// states, seven-segment codes and the double-dabble helper.
package system_hex_bcd_pkg;

  // Avalon-MM word offsets
  localparam logic [1:0] AddrValue  = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrBcd    = 2'd2;
  localparam logic [1:0] AddrCtrl   = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StLoad  = 2'd2
  } state_e;

  // One double-dabble iteration per input bit
  localparam int unsigned IterCount = 16;

  // Active-low segment codes, bit0 = a .. bit6 = g
  localparam logic [6:0] SegDigit0 = 7'h40;
  localparam logic [6:0] SegDigit1 = 7'h79;
  localparam logic [6:0] SegDigit2 = 7'h24;
  localparam logic [6:0] SegDigit3 = 7'h30;
  localparam logic [6:0] SegDigit4 = 7'h19;
  localparam logic [6:0] SegDigit5 = 7'h12;
  localparam logic [6:0] SegDigit6 = 7'h02;
  localparam logic [6:0] SegDigit7 = 7'h78;
  localparam logic [6:0] SegDigit8 = 7'h00;
  localparam logic [6:0] SegDigit9 = 7'h10;
  localparam logic [6:0] SegBlank  = 7'h7F;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift
  function automatic logic [19:0] dabble_adjust(input logic [19:0] bcd);
    logic [19:0] res;
    res = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/system_hex_bcd_seg7.sv
// BCD digit to active-low seven-segment code; blank forces all segments off.
module system_hex_bcd_seg7
  import system_hex_bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Digit decode; non-decimal codes show blank
  always_comb begin
    seg = SegBlank;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SegDigit0;
        4'd1:    seg = SegDigit1;
        4'd2:    seg = SegDigit2;
        4'd3:    seg = SegDigit3;
        4'd4:    seg = SegDigit4;
        4'd5:    seg = SegDigit5;
        4'd6:    seg = SegDigit6;
        4'd7:    seg = SegDigit7;
        4'd8:    seg = SegDigit8;
        4'd9:    seg = SegDigit9;
        default: seg = SegBlank;
      endcase
    end
  end

endmodule

// File: rtl/system_hex_bcd.sv
// 16-bit binary to 5-digit BCD converter with Avalon-MM slave and five
// seven-segment outputs. Define HEX_BCD_BLANK_EN to blank leading zero digits.
module system_hex_bcd
  import system_hex_bcd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] work_q, work_d;
  logic [15:0] value_q, value_d;
  logic [19:0] bcd_q, bcd_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic        disp_en_q, disp_en_d;

  logic        wr;
  logic        value_wr;
  logic        status_rd;
  logic        busy;
  logic [19:0] adj;
  logic [4:0]  blank;
  logic [6:0]  hex_seg [5];
  logic        unused_wd;

  assign wr        = chipselect && !write_n;
  assign value_wr  = wr && (address == AddrValue);
  assign status_rd = chipselect && read && (address == AddrStatus);
  assign busy      = (state_q != StIdle);
  assign unused_wd = ^writedata[31:16];

  // State and register file update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bin_q     <= '0;
      work_q    <= '0;
      value_q   <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      disp_en_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      work_q    <= work_d;
      value_q   <= value_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      disp_en_q <= disp_en_d;
    end
  end

  // Next-state: conversion FSM plus status flag handling
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    work_d    = work_q;
    value_d   = value_q;
    bcd_d     = bcd_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    disp_en_d = disp_en_q;
    adj       = dabble_adjust(work_q);

    // Clear first so that set events below win on the same edge
    if (status_rd) begin
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end

    if (wr && (address == AddrCtrl)) begin
      disp_en_d = writedata[0];
    end

    unique case (state_q)
      StIdle: begin
        if (value_wr) begin
          value_d = writedata[15:0];
          bin_d   = writedata[15:0];
          work_d  = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        work_d = {adj[18:0], bin_q[15]};
        bin_d  = {bin_q[14:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(IterCount - 1)) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        bcd_d   = work_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A second VALUE write during a conversion is dropped and flagged
    if (value_wr && busy) begin
      overrun_d = 1'b1;
    end
  end

  // Read mux, zero wait states
  always_comb begin
    readdata = '0;
    unique case (address)
      AddrValue:  readdata[15:0] = value_q;
      AddrStatus: readdata[2:0]  = {overrun_q, done_q, busy};
      AddrBcd:    readdata[19:0] = bcd_q;
      AddrCtrl:   readdata[0]    = disp_en_q;
      default:    readdata       = '0;
    endcase
  end

  // Per-digit blanking: display disable, and optionally leading zeros
  always_comb begin
    blank = '0;
`ifdef HEX_BCD_BLANK_EN
    blank[4] = (bcd_q[19:16] == 4'd0);
    blank[3] = blank[4] && (bcd_q[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
`endif
    if (!disp_en_q) begin
      blank = '1;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_seg
    system_hex_bcd_seg7 u_seg7 (
      .digit (bcd_q[i*4 +: 4]),
      .blank (blank[i]),
      .seg   (hex_seg[i])
    );
  end

  assign hex0 = hex_seg[0];
  assign hex1 = hex_seg[1];
  assign hex2 = hex_seg[2];
  assign hex3 = hex_seg[3];
  assign hex4 = hex_seg[4];

endmodule

// File: tb/tb_system_hex_bcd.sv
// Self-checking bench for system_hex_bcd. Expected BCD values come from a
// decimal-division model; expected segment codes from a bench-side table.
module tb_system_hex_bcd;

  localparam logic [1:0] AValue  = 2'd0;
  localparam logic [1:0] AStatus = 2'd1;
  localparam logic [1:0] ABcd    = 2'd2;
  localparam logic [1:0] ACtrl   = 2'd3;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [15:0] value;
    logic [19:0] bcd;
  } exp_t;

  exp_t sb[$];

  system_hex_bcd dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read       (read),
    .writedata  (writedata),
    .readdata   (readdata),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    t = v;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[k*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex(input logic [19:0] b, input logic en, input int i);
    logic [3:0] d;
    bit lead;
    d = b[i*4 +: 4];
    if (!en) return 7'h7F;
    lead = 1'b1;
    for (int k = 4; k > i; k--) begin
      if (b[k*4 +: 4] != 4'd0) lead = 1'b0;
    end
`ifdef HEX_BCD_BLANK_EN
    if (i != 0 && lead && d == 4'd0) return 7'h7F;
`endif
    return seg_of(d);
  endfunction

  function automatic logic [6:0] get_hex(input int i);
    case (i)
      0: return hex0;
      1: return hex1;
      2: return hex2;
      3: return hex3;
      default: return hex4;
    endcase
  endfunction

  // ---------------- bus tasks ----------------
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic status_read(output logic [31:0] d);
    address    = AStatus;
    chipselect = 1'b1;
    read       = 1'b1;
    #1;
    d = readdata;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic start_convert(input logic [15:0] v);
    exp_t e;
    e.value = v;
    e.bcd   = to_bcd(int'(v));
    sb.push_back(e);
    bus_write(AValue, {16'd0, v});
  endtask

  // Counts edges until busy drops; bounded
  task automatic wait_idle(output int n);
    n = 0;
    address = AStatus;
    #1;
    while (readdata[0] === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_idle timeout: busy still %b after %0d cycles, required 0", readdata[0], n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    peek(AValue, d);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL reset_value got %h want 0", d); end
    peek(AStatus, d);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL reset_status got %h want 0", d); end
    peek(ABcd, d);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL reset_bcd got %h want 0", d); end
    peek(ACtrl, d);
    tests_run++;
    if (d !== 32'd1) begin tests_failed++; $display("FAIL reset_ctrl got %h want 1", d); end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (get_hex(i) !== exp_hex(20'd0, 1'b1, i)) begin
        tests_failed++;
        $display("FAIL reset_hex%0d got %h want %h", i, get_hex(i), exp_hex(20'd0, 1'b1, i));
      end
    end
  endtask

  task automatic test_convert();
    int n;
    exp_t e;
    logic [31:0] d;
    align();
    start_convert(16'd12345);
    wait_idle(n);
    tests_run++;
    if (n !== 17) begin tests_failed++; $display("FAIL busy_cycles got %0d want 17", n); end
    e = sb.pop_front();
    peek(ABcd, d);
    tests_run++;
    if (d !== {12'd0, e.bcd}) begin tests_failed++; $display("FAIL conv_bcd got %h want %h", d, e.bcd); end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (get_hex(i) !== exp_hex(e.bcd, 1'b1, i)) begin
        tests_failed++;
        $display("FAIL conv_hex%0d got %h want %h", i, get_hex(i), exp_hex(e.bcd, 1'b1, i));
      end
    end
    peek(AValue, d);
    tests_run++;
    if (d !== {16'd0, e.value}) begin tests_failed++; $display("FAIL conv_value got %h want %h", d, e.value); end
    status_read(d);
    tests_run++;
    if (d[2:0] !== 3'b010) begin tests_failed++; $display("FAIL conv_status got %b want 010", d[2:0]); end
    peek(AStatus, d);
    tests_run++;
    if (d[2:0] !== 3'b000) begin tests_failed++; $display("FAIL done_clear got %b want 000", d[2:0]); end
  endtask

  task automatic test_boundaries();
    int n;
    exp_t e;
    logic [31:0] d;
    logic [15:0] vals [6];
    vals = '{16'd65535, 16'd7, 16'd0, 16'd9, 16'd10, 16'd10000};
    foreach (vals[k]) begin
      start_convert(vals[k]);
      wait_idle(n);
      e = sb.pop_front();
      peek(ABcd, d);
      tests_run++;
      if (d !== {12'd0, e.bcd}) begin
        tests_failed++;
        $display("FAIL bound_bcd(%0d) got %h want %h", e.value, d, e.bcd);
      end
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (get_hex(i) !== exp_hex(e.bcd, 1'b1, i)) begin
          tests_failed++;
          $display("FAIL bound_hex%0d(%0d) got %h want %h", i, e.value, get_hex(i),
                   exp_hex(e.bcd, 1'b1, i));
        end
      end
    end
  endtask

  task automatic test_overrun();
    int n;
    exp_t e;
    logic [31:0] d;
    status_read(d);
    start_convert(16'd100);
    repeat (4) @(posedge clk);
    #1;
    bus_write(AValue, 32'd200);
    wait_idle(n);
    e = sb.pop_front();
    peek(ABcd, d);
    tests_run++;
    if (d !== {12'd0, e.bcd}) begin tests_failed++; $display("FAIL ovr_bcd got %h want %h", d, e.bcd); end
    peek(AValue, d);
    tests_run++;
    if (d !== {16'd0, e.value}) begin tests_failed++; $display("FAIL ovr_value got %h want %h", d, e.value); end
    peek(AStatus, d);
    tests_run++;
    if (d[2:0] !== 3'b110) begin tests_failed++; $display("FAIL ovr_status got %b want 110", d[2:0]); end
    status_read(d);
    peek(AStatus, d);
    tests_run++;
    if (d[2:0] !== 3'b000) begin tests_failed++; $display("FAIL ovr_clear got %b want 000", d[2:0]); end
  endtask

  // STATUS read on the LOAD edge: done must still be set afterwards
  task automatic test_set_wins();
    int n;
    exp_t e;
    logic [31:0] d;
    start_convert(16'd321);
    repeat (16) @(posedge clk);
    #1;
    status_read(d);
    tests_run++;
    if (d[1:0] !== 2'b01) begin tests_failed++; $display("FAIL setwin_pre got %b want 01", d[1:0]); end
    wait_idle(n);
    e = sb.pop_front();
    peek(AStatus, d);
    tests_run++;
    if (d[1:0] !== 2'b10) begin tests_failed++; $display("FAIL setwin_done got %b want 10", d[1:0]); end
    peek(ABcd, d);
    tests_run++;
    if (d !== {12'd0, e.bcd}) begin tests_failed++; $display("FAIL setwin_bcd got %h want %h", d, e.bcd); end
  endtask

  task automatic test_display_en();
    int n;
    exp_t e;
    logic [31:0] d;
    start_convert(16'd42);
    wait_idle(n);
    e = sb.pop_front();
    bus_write(ACtrl, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (get_hex(i) !== 7'h7F) begin
        tests_failed++;
        $display("FAIL dis_hex%0d got %h want 7f", i, get_hex(i));
      end
    end
    peek(ABcd, d);
    tests_run++;
    if (d !== {12'd0, e.bcd}) begin tests_failed++; $display("FAIL dis_bcd got %h want %h", d, e.bcd); end
    peek(ACtrl, d);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL dis_ctrl got %h want 0", d); end
    // Conversions keep running while the display is off
    start_convert(16'd58);
    wait_idle(n);
    e = sb.pop_front();
    peek(ABcd, d);
    tests_run++;
    if (d !== {12'd0, e.bcd}) begin tests_failed++; $display("FAIL dis_conv got %h want %h", d, e.bcd); end
    start_convert(16'd42);
    wait_idle(n);
    e = sb.pop_front();
    bus_write(ACtrl, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (get_hex(i) !== exp_hex(e.bcd, 1'b1, i)) begin
        tests_failed++;
        $display("FAIL en_hex%0d got %h want %h", i, get_hex(i), exp_hex(e.bcd, 1'b1, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    exp_t e;
    logic [31:0] d;
    for (int k = 0; k < 6; k++) begin
      start_convert(16'($urandom_range(0, 65535)));
      wait_idle(n);
      e = sb.pop_front();
      tests_run++;
      if (n !== 17) begin tests_failed++; $display("FAIL b2b_busy(%0d) got %0d want 17", e.value, n); end
      peek(ABcd, d);
      tests_run++;
      if (d !== {12'd0, e.bcd}) begin
        tests_failed++;
        $display("FAIL b2b_bcd(%0d) got %h want %h", e.value, d, e.bcd);
      end
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (get_hex(i) !== exp_hex(e.bcd, 1'b1, i)) begin
          tests_failed++;
          $display("FAIL b2b_hex%0d(%0d) got %h want %h", i, e.value, get_hex(i),
                   exp_hex(e.bcd, 1'b1, i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    status_read(d);
    start_convert(16'd999);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    peek(AStatus, d);
    tests_run++;
    if (d[2:0] !== 3'b000) begin tests_failed++; $display("FAIL rmid_status got %b want 000", d[2:0]); end
    peek(ABcd, d);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL rmid_bcd got %h want 0", d); end
    repeat (25) @(posedge clk);
    #1;
    peek(AStatus, d);
    tests_run++;
    if (d[2:0] !== 3'b000) begin tests_failed++; $display("FAIL rmid_late_status got %b want 000", d[2:0]); end
    peek(ABcd, d);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL rmid_late_bcd got %h want 0", d); end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (get_hex(i) !== exp_hex(20'd0, 1'b1, i)) begin
        tests_failed++;
        $display("FAIL rmid_hex%0d got %h want %h", i, get_hex(i), exp_hex(20'd0, 1'b1, i));
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read       = 1'b0;
    writedata  = '0;
    test_reset();
    test_convert();
    test_boundaries();
    test_overrun();
    test_set_wins();
    test_display_en();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
